// File: rtl/decode_dispatch_queue.sv
// decode_dispatch_queue
//   Buffered decode/dispatch stage between instruction fetch and the ROB/RS/LSB
//   back end. Fetched instructions are held in an IQ_DEPTH-entry FIFO. The head
//   entry is decoded into the 6-bit op encoding, given a ROB tag and dispatched
//   (registered, one-cycle pulses) once every consumer it needs has space.
//   Undecodable head entries are dropped with a one-cycle illegal pulse.
//
// Ports
//   clk_in, rst_in        clock, asynchronous active-low reset
//   rdy_in                global enable (0 freezes state, no pulses)
//   clear                 synchronous flush: empties queue, resets tag
//   if_valid/if_pc/if_inst/if_ready   fetch-side valid/ready push interface
//   rob_ready/rs_ready/lsb_ready      consumer free-slot indications
//   to_rob/to_rs/to_lsb   dispatch pulses
//   d_op..d_tag           registered dispatch payload
//   illegal               pulse: head entry was undecodable (d_pc = its pc)
//   iq_count              current queue occupancy
module decode_dispatch_queue #(
    parameter int ROB_WIDTH = 4,
    parameter int IQ_WIDTH  = 2,
    parameter int IQ_DEPTH  = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 if_valid,
    input  logic [31:0]          if_pc,
    input  logic [31:0]          if_inst,
    output logic                 if_ready,
    input  logic                 rob_ready,
    input  logic                 rs_ready,
    input  logic                 lsb_ready,
    output logic                 to_rob,
    output logic                 to_rs,
    output logic                 to_lsb,
    output logic [5:0]           d_op,
    output logic [4:0]           d_rd,
    output logic [4:0]           d_rs1,
    output logic [4:0]           d_rs2,
    output logic [31:0]          d_imm,
    output logic [31:0]          d_pc,
    output logic [ROB_WIDTH-1:0] d_tag,
    output logic                 illegal,
    output logic [IQ_WIDTH:0]    iq_count
);

    typedef enum logic [5:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU,
        OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BGE, OP_BGEU, OP_BLT, OP_BLTU, OP_BNE,
        OP_JAL, OP_JALR, OP_AUIPC, OP_LUI
    } op_e;

    localparam logic [IQ_WIDTH:0] LP_FULL = (IQ_WIDTH + 1)'(IQ_DEPTH);

    logic [31:0]          r_pc_mem   [IQ_DEPTH];
    logic [31:0]          r_inst_mem [IQ_DEPTH];
    logic [IQ_WIDTH-1:0]  r_head;
    logic [IQ_WIDTH-1:0]  r_tail;
    logic [IQ_WIDTH:0]    r_count;
    logic [ROB_WIDTH-1:0] r_tag;

    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic [2:0]  w_f3;
    logic        w_f7_zero;
    logic        w_f7_alt;
    logic [31:0] w_imm_i, w_imm_sh, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
    op_e         w_op;
    logic        w_illegal;
    logic        w_mem;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [31:0] w_imm;
    logic        w_empty;
    logic        w_active;
    logic        w_disp;
    logic        w_pop_ill;
    logic        w_pop;
    logic        w_push;

    assign w_inst    = r_inst_mem[r_head];
    assign w_pc      = r_pc_mem[r_head];
    assign w_f3      = w_inst[14:12];
    assign w_f7_zero = (w_inst[31:25] == 7'b0000000);
    assign w_f7_alt  = (w_inst[31:25] == 7'b0100000);

    assign w_imm_i  = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_sh = {27'd0, w_inst[24:20]};
    assign w_imm_s  = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b  = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_j  = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
    assign w_imm_u  = {w_inst[31:12], 12'd0};

    // Head decoder. Unused source fields are zeroed so the back end never
    // sees stale register numbers for formats that have no such operand.
    always_comb begin
        w_op      = OP_ADD;
        w_illegal = 1'b1;
        w_mem     = 1'b0;
        w_rd      = w_inst[11:7];
        w_rs1     = w_inst[19:15];
        w_rs2     = w_inst[24:20];
        w_imm     = '0;
        case (w_inst[6:0])
            7'b0110011: begin
                w_illegal = !w_f7_zero;
                case (w_f3)
                    3'b000: begin
                        w_op      = w_f7_alt ? OP_SUB : OP_ADD;
                        w_illegal = !(w_f7_zero || w_f7_alt);
                    end
                    3'b001: w_op = OP_SLL;
                    3'b010: w_op = OP_SLT;
                    3'b011: w_op = OP_SLTU;
                    3'b100: w_op = OP_XOR;
                    3'b101: begin
                        w_op      = w_f7_alt ? OP_SRA : OP_SRL;
                        w_illegal = !(w_f7_zero || w_f7_alt);
                    end
                    3'b110: w_op = OP_OR;
                    default: w_op = OP_AND;
                endcase
            end
            7'b0010011: begin
                w_rs2     = '0;
                w_imm     = w_imm_i;
                w_illegal = 1'b0;
                case (w_f3)
                    3'b000: w_op = OP_ADDI;
                    3'b001: begin
                        w_op      = OP_SLLI;
                        w_imm     = w_imm_sh;
                        w_illegal = !w_f7_zero;
                    end
                    3'b010: w_op = OP_SLTI;
                    3'b011: w_op = OP_SLTIU;
                    3'b100: w_op = OP_XORI;
                    3'b101: begin
                        w_op      = w_f7_alt ? OP_SRAI : OP_SRLI;
                        w_imm     = w_imm_sh;
                        w_illegal = !(w_f7_zero || w_f7_alt);
                    end
                    3'b110: w_op = OP_ORI;
                    default: w_op = OP_ANDI;
                endcase
            end
            7'b0000011: begin
                w_rs2     = '0;
                w_imm     = w_imm_i;
                w_mem     = 1'b1;
                w_illegal = 1'b0;
                case (w_f3)
                    3'b000: w_op = OP_LB;
                    3'b001: w_op = OP_LH;
                    3'b010: w_op = OP_LW;
                    3'b100: w_op = OP_LBU;
                    3'b101: w_op = OP_LHU;
                    default: w_illegal = 1'b1;
                endcase
            end
            7'b0100011: begin
                w_rd      = '0;
                w_imm     = w_imm_s;
                w_mem     = 1'b1;
                w_illegal = 1'b0;
                case (w_f3)
                    3'b000: w_op = OP_SB;
                    3'b001: w_op = OP_SH;
                    3'b010: w_op = OP_SW;
                    default: w_illegal = 1'b1;
                endcase
            end
            7'b1100011: begin
                w_rd      = '0;
                w_imm     = w_imm_b;
                w_illegal = 1'b0;
                case (w_f3)
                    3'b000: w_op = OP_BEQ;
                    3'b001: w_op = OP_BNE;
                    3'b100: w_op = OP_BLT;
                    3'b101: w_op = OP_BGE;
                    3'b110: w_op = OP_BLTU;
                    3'b111: w_op = OP_BGEU;
                    default: w_illegal = 1'b1;
                endcase
            end
            7'b1101111: begin
                w_op      = OP_JAL;
                w_rs1     = '0;
                w_rs2     = '0;
                w_imm     = w_imm_j;
                w_illegal = 1'b0;
            end
            7'b1100111: begin
                w_op      = OP_JALR;
                w_rs2     = '0;
                w_imm     = w_imm_i;
                w_illegal = (w_f3 != 3'b000);
            end
            7'b0010111: begin
                w_op      = OP_AUIPC;
                w_rs1     = '0;
                w_rs2     = '0;
                w_imm     = w_imm_u;
                w_illegal = 1'b0;
            end
            7'b0110111: begin
                w_op      = OP_LUI;
                w_rs1     = '0;
                w_rs2     = '0;
                w_imm     = w_imm_u;
                w_illegal = 1'b0;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign if_ready  = (r_count != LP_FULL);
    assign iq_count  = r_count;
    assign w_empty   = (r_count == '0);
    assign w_active  = rdy_in && !clear;
    // Illegal heads are dropped without waiting on any consumer.
    assign w_pop_ill = w_active && !w_empty && w_illegal;
    assign w_disp    = w_active && !w_empty && !w_illegal && rob_ready && rs_ready
                       && (!w_mem || lsb_ready);
    assign w_pop     = w_disp || w_pop_ill;
    assign w_push    = w_active && if_valid && if_ready;

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_pc_mem[r_tail]   <= if_pc;
            r_inst_mem[r_tail] <= if_inst;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_tag    <= '0;
            to_rob   <= 1'b0;
            to_rs    <= 1'b0;
            to_lsb   <= 1'b0;
            illegal  <= 1'b0;
            d_op     <= '0;
            d_rd     <= '0;
            d_rs1    <= '0;
            d_rs2    <= '0;
            d_imm    <= '0;
            d_pc     <= '0;
            d_tag    <= '0;
        end else begin
            // Pulse terms already fold in rdy_in and clear.
            to_rob  <= w_disp;
            to_rs   <= w_disp;
            to_lsb  <= w_disp && w_mem;
            illegal <= w_pop_ill;
            if (clear) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_tag   <= '0;
            end else if (rdy_in) begin
                if (w_push) r_tail <= r_tail + 1'b1;
                if (w_pop)  r_head <= r_head + 1'b1;
                if (w_push && !w_pop)      r_count <= r_count + 1'b1;
                else if (!w_push && w_pop) r_count <= r_count - 1'b1;
                if (w_disp) begin
                    d_op  <= w_op;
                    d_rd  <= w_rd;
                    d_rs1 <= w_rs1;
                    d_rs2 <= w_rs2;
                    d_imm <= w_imm;
                    d_pc  <= w_pc;
                    d_tag <= r_tag;
                    r_tag <= r_tag + 1'b1;
                end else if (w_pop_ill) begin
                    d_pc <= w_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_dispatch_queue.sv
// tb_decode_dispatch_queue
//   Directed self-checking bench for decode_dispatch_queue: reset state,
//   decode/immediate formats, unit routing and back-pressure, full queue,
//   tag wrap, illegal-instruction drop, flush and global enable.
module tb_decode_dispatch_queue;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        rob_ready, rs_ready, lsb_ready;
    logic        to_rob, to_rs, to_lsb;
    logic [5:0]  d_op;
    logic [4:0]  d_rd, d_rs1, d_rs2;
    logic [31:0] d_imm, d_pc;
    logic [3:0]  d_tag;
    logic        illegal;
    logic [2:0]  iq_count;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_ADDI = 32'hFFB00093;
    localparam logic [31:0] I_SW   = 32'h0020A423;
    localparam logic [31:0] I_ADD  = 32'h002081B3;

    logic [31:0] dec_inst [8] = '{32'h002081B3, 32'h402081B3, 32'h40315093, 32'h123452B7,
                                  32'hFE208EE3, 32'h008000EF, 32'hFF80A203, 32'hFFF03093};
    logic [5:0]  dec_op   [8] = '{6'd0, 6'd1, 6'd16, 6'd36, 6'd27, 6'd33, 6'd23, 6'd18};
    logic [4:0]  dec_rd   [8] = '{5'd3, 5'd3, 5'd1, 5'd5, 5'd0, 5'd1, 5'd4, 5'd1};
    logic [31:0] dec_imm  [8] = '{32'h0, 32'h0, 32'h3, 32'h12345000,
                                  32'hFFFFFFFC, 32'h8, 32'hFFFFFFF8, 32'hFFFFFFFF};
    logic [3:0]  dec_pul  [8] = '{4'b1100, 4'b1100, 4'b1100, 4'b1100,
                                  4'b1100, 4'b1100, 4'b1110, 4'b1100};

    always #5 clk_in = ~clk_in;

    decode_dispatch_queue #(
        .ROB_WIDTH(4),
        .IQ_WIDTH (2),
        .IQ_DEPTH (4)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .clear    (clear),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .rob_ready(rob_ready),
        .rs_ready (rs_ready),
        .lsb_ready(lsb_ready),
        .to_rob   (to_rob),
        .to_rs    (to_rs),
        .to_lsb   (to_lsb),
        .d_op     (d_op),
        .d_rd     (d_rd),
        .d_rs1    (d_rs1),
        .d_rs2    (d_rs2),
        .d_imm    (d_imm),
        .d_pc     (d_pc),
        .d_tag    (d_tag),
        .illegal  (illegal),
        .iq_count (iq_count)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in    = 1'b0;
        rdy_in    = 1'b1;
        clear     = 1'b0;
        if_valid  = 1'b0;
        if_pc     = '0;
        if_inst   = '0;
        rob_ready = 1'b1;
        rs_ready  = 1'b1;
        lsb_ready = 1'b1;
        tick();
        tick();
        rst_in = 1'b1;
        tick();
    endtask

    // One push cycle; the entry is at the head when this returns.
    task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
        if_valid = 1'b1;
        if_pc    = pc;
        if_inst  = inst;
        tick();
        if_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({iq_count, if_ready, to_rob, to_rs, to_lsb, illegal} !== 8'b000_1_0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=%b",
                     {iq_count, if_ready, to_rob, to_rs, to_lsb, illegal}, 8'b000_1_0000);
        end
        total++;
        if ({d_op, d_rd, d_rs1, d_rs2, d_imm, d_pc, d_tag} !== '0) begin
            bad++;
            $display("FAIL reset_payload got op=%0d rd=%0d imm=%h pc=%h tag=%0d exp all zero",
                     d_op, d_rd, d_imm, d_pc, d_tag);
        end
        // Asynchronous reset: queue must empty between clock edges.
        rs_ready = 1'b0;
        push_one(32'h40, I_ADD);
        push_one(32'h44, I_ADD);
        #2 rst_in = 1'b0;
        #1;
        total++;
        if (iq_count !== 3'd0) begin
            bad++;
            $display("FAIL async_reset iq_count got=%0d exp=0", iq_count);
        end
        do_reset();
    endtask

    task automatic test_addi();
        do_reset();
        push_one(32'h0, I_ADDI);
        total++;
        if ({to_rob, to_rs, iq_count} !== 5'b00_001) begin
            bad++;
            $display("FAIL addi_pushed got=%b exp=%b", {to_rob, to_rs, iq_count}, 5'b00_001);
        end
        tick();
        total++;
        if ({to_rob, to_rs, to_lsb, illegal} !== 4'b1100) begin
            bad++;
            $display("FAIL addi_pulses got=%b exp=1100", {to_rob, to_rs, to_lsb, illegal});
        end
        total++;
        if ({d_op, d_rd, d_imm, d_tag, d_pc} !== {6'd10, 5'd1, 32'hFFFFFFFB, 4'd0, 32'h0}) begin
            bad++;
            $display("FAIL addi_payload got op=%0d rd=%0d imm=%h tag=%0d pc=%h exp op=10 rd=1 imm=fffffffb tag=0 pc=0",
                     d_op, d_rd, d_imm, d_tag, d_pc);
        end
        tick();
        total++;
        if ({to_rob, to_rs, to_lsb, iq_count} !== 6'b000_000) begin
            bad++;
            $display("FAIL addi_pulse_width got=%b exp=000000", {to_rob, to_rs, to_lsb, iq_count});
        end
    endtask

    task automatic test_store_route();
        do_reset();
        push_one(32'h10, I_SW);
        tick();
        total++;
        if ({to_rob, to_rs, to_lsb, illegal} !== 4'b1110) begin
            bad++;
            $display("FAIL sw_pulses got=%b exp=1110", {to_rob, to_rs, to_lsb, illegal});
        end
        total++;
        if ({d_op, d_rd, d_rs1, d_rs2, d_imm, d_tag} !== {6'd26, 5'd0, 5'd1, 5'd2, 32'd8, 4'd0}) begin
            bad++;
            $display("FAIL sw_payload got op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h tag=%0d exp op=26 rd=0 rs1=1 rs2=2 imm=8 tag=0",
                     d_op, d_rd, d_rs1, d_rs2, d_imm, d_tag);
        end
        lsb_ready = 1'b0;
        push_one(32'h14, I_SW);
        tick();
        tick();
        total++;
        if ({to_rob, to_rs, to_lsb, iq_count, d_tag, d_pc} !== {3'b000, 3'd1, 4'd0, 32'h10}) begin
            bad++;
            $display("FAIL sw_held got pulses=%b cnt=%0d tag=%0d pc=%h exp 000 1 0 10",
                     {to_rob, to_rs, to_lsb}, iq_count, d_tag, d_pc);
        end
        lsb_ready = 1'b1;
        tick();
        total++;
        if ({to_rob, to_rs, to_lsb, iq_count, d_tag, d_pc} !== {3'b111, 3'd0, 4'd1, 32'h14}) begin
            bad++;
            $display("FAIL sw_release got pulses=%b cnt=%0d tag=%0d pc=%h exp 111 0 1 14",
                     {to_rob, to_rs, to_lsb}, iq_count, d_tag, d_pc);
        end
    endtask

    task automatic test_decode();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push_one(32'h200 + 32'(i * 4), dec_inst[i]);
            tick();
            total++;
            if ({to_rob, to_rs, to_lsb, illegal} !== dec_pul[i] || d_op !== dec_op[i] ||
                d_rd !== dec_rd[i] || d_imm !== dec_imm[i] || d_tag !== 4'(i)) begin
                bad++;
                $display("FAIL decode_%0d got pul=%b op=%0d rd=%0d imm=%h tag=%0d exp pul=%b op=%0d rd=%0d imm=%h tag=%0d",
                         i, {to_rob, to_rs, to_lsb, illegal}, d_op, d_rd, d_imm, d_tag,
                         dec_pul[i], dec_op[i], dec_rd[i], dec_imm[i], 4'(i));
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        rs_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'(i * 4), I_ADD);
        total++;
        if ({iq_count, if_ready, to_rob} !== 5'b100_0_0) begin
            bad++;
            $display("FAIL full_state got cnt=%0d if_ready=%b to_rob=%b exp 4 0 0", iq_count, if_ready, to_rob);
        end
        // Push offered while full and popping: must not be accepted.
        rs_ready = 1'b1;
        if_valid = 1'b1;
        if_pc    = 32'h99;
        if_inst  = I_ADD;
        tick();
        if_valid = 1'b0;
        total++;
        if ({to_rob, d_tag, d_pc, iq_count, if_ready} !== {1'b1, 4'd0, 32'h0, 3'd3, 1'b1}) begin
            bad++;
            $display("FAIL full_pop0 got to_rob=%b tag=%0d pc=%h cnt=%0d rdy=%b exp 1 0 0 3 1",
                     to_rob, d_tag, d_pc, iq_count, if_ready);
        end
        for (int i = 1; i < 4; i++) begin
            tick();
            total++;
            if ({to_rob, to_rs, d_tag, d_pc} !== {2'b11, 4'(i), 32'(i * 4)}) begin
                bad++;
                $display("FAIL full_pop%0d got pulses=%b tag=%0d pc=%h exp 11 %0d %h",
                         i, {to_rob, to_rs}, d_tag, d_pc, i, i * 4);
            end
        end
        tick();
        total++;
        if ({to_rob, to_rs, iq_count} !== 5'b00_000) begin
            bad++;
            $display("FAIL full_drained got=%b exp=00000", {to_rob, to_rs, iq_count});
        end
    endtask

    task automatic test_tag_wrap();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if_valid = (i < 17);
            if_pc    = 32'h1000 + 32'(i * 4);
            if_inst  = I_ADD;
            tick();
            if (i >= 1) begin
                total++;
                if ({to_rob, d_tag, d_pc, iq_count} !==
                    {1'b1, 4'(i - 1), 32'h1000 + 32'((i - 1) * 4), (i < 17) ? 3'd1 : 3'd0}) begin
                    bad++;
                    $display("FAIL wrap_%0d got to_rob=%b tag=%0d pc=%h cnt=%0d exp tag=%0d",
                             i, to_rob, d_tag, d_pc, iq_count, (i - 1) % 16);
                end
            end
        end
        if_valid = 1'b0;
    endtask

    task automatic test_illegal();
        do_reset();
        push_one(32'h100, I_ADD);
        if_valid = 1'b1;
        if_pc    = 32'h104;
        if_inst  = 32'hFFFFFFFF;
        tick();
        if_pc    = 32'h108;
        if_inst  = I_ADD;
        total++;
        if ({to_rob, illegal, d_tag, d_pc} !== {2'b10, 4'd0, 32'h100}) begin
            bad++;
            $display("FAIL ill_first got to_rob=%b ill=%b tag=%0d pc=%h exp 1 0 0 100", to_rob, illegal, d_tag, d_pc);
        end
        tick();
        if_valid = 1'b0;
        total++;
        if ({to_rob, to_rs, to_lsb, illegal, d_pc} !== {4'b0001, 32'h104}) begin
            bad++;
            $display("FAIL ill_pulse got pulses=%b pc=%h exp 0001 104", {to_rob, to_rs, to_lsb, illegal}, d_pc);
        end
        tick();
        total++;
        if ({to_rob, illegal, d_tag, d_pc} !== {2'b10, 4'd1, 32'h108}) begin
            bad++;
            $display("FAIL ill_after got to_rob=%b ill=%b tag=%0d pc=%h exp 1 0 1 108", to_rob, illegal, d_tag, d_pc);
        end
        // Bad funct7 on an R-type, no consumer ready: still dropped.
        rob_ready = 1'b0;
        rs_ready  = 1'b0;
        push_one(32'h10C, 32'h202081B3);
        tick();
        total++;
        if ({to_rob, illegal, d_pc, iq_count} !== {2'b01, 32'h10C, 3'd0}) begin
            bad++;
            $display("FAIL ill_f7 got to_rob=%b ill=%b pc=%h cnt=%0d exp 0 1 10c 0", to_rob, illegal, d_pc, iq_count);
        end
        rob_ready = 1'b1;
        rs_ready  = 1'b1;
    endtask

    task automatic test_clear();
        do_reset();
        push_one(32'h300, I_ADD);
        tick();
        rs_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(32'h304 + 32'(i * 4), I_ADD);
        total++;
        if (iq_count !== 3'd3) begin
            bad++;
            $display("FAIL clr_fill got cnt=%0d exp 3", iq_count);
        end
        rs_ready = 1'b1;
        clear    = 1'b1;
        if_valid = 1'b1;
        if_pc    = 32'h3F0;
        if_inst  = I_ADD;
        tick();
        clear    = 1'b0;
        if_valid = 1'b0;
        total++;
        if ({iq_count, to_rob, to_rs, to_lsb, illegal} !== 7'b000_0000) begin
            bad++;
            $display("FAIL clr_state got cnt=%0d pulses=%b exp 0 0000", iq_count, {to_rob, to_rs, to_lsb, illegal});
        end
        push_one(32'h400, I_ADD);
        tick();
        total++;
        if ({to_rob, d_tag, d_pc} !== {1'b1, 4'd0, 32'h400}) begin
            bad++;
            $display("FAIL clr_tag got to_rob=%b tag=%0d pc=%h exp 1 0 400", to_rob, d_tag, d_pc);
        end
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        rdy_in = 1'b0;
        push_one(32'h500, I_ADD);
        total++;
        if ({iq_count, if_ready} !== 4'b000_1) begin
            bad++;
            $display("FAIL frz_nopush got cnt=%0d rdy=%b exp 0 1", iq_count, if_ready);
        end
        rdy_in = 1'b1;
        push_one(32'h504, I_ADD);
        rdy_in = 1'b0;
        tick();
        tick();
        total++;
        if ({to_rob, to_rs, iq_count} !== 5'b00_001) begin
            bad++;
            $display("FAIL frz_hold got pulses=%b cnt=%0d exp 00 1", {to_rob, to_rs}, iq_count);
        end
        rdy_in = 1'b1;
        tick();
        total++;
        if ({to_rob, d_tag, d_pc} !== {1'b1, 4'd0, 32'h504}) begin
            bad++;
            $display("FAIL frz_release got to_rob=%b tag=%0d pc=%h exp 1 0 504", to_rob, d_tag, d_pc);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store_route();
        test_decode();
        test_full();
        test_tag_wrap();
        test_illegal();
        test_clear();
        test_rdy_freeze();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
